// File: rtl/de_arb_pkg.sv
// de_arb_pkg: shared widths and state encoding for the display-engine port arbiter.
//   DE_ADDR_W  - word address width of the frame-store port
//   DE_DATA_W  - data width of the frame-store port
//   DE_NBYTE_W - active-low byte-lane mask width
//   arb_state_t - arbiter FSM state encoding
package de_arb_pkg;

  localparam int DE_ADDR_W  = 18;
  localparam int DE_DATA_W  = 32;
  localparam int DE_NBYTE_W = 4;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/de_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  N      request vector
//   last  in  IDX_W  index of the most recent grantee; search starts at last+1
//                    and wraps around, ending at last itself
//   idx   out IDX_W  chosen requester (0 when valid is low)
//   valid out 1      at least one request present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // First active request at increasing distance from last; distance N is last itself,
  // so the previous grantee only wins when nobody else is asking.
  always_comb begin
    int j;
    idx   = {IDX_W{1'b0}};
    valid = 1'b0;
    j     = 0;
    for (int off = 1; off <= N; off++) begin
      j = (int'(last) + off) % N;
      if (!valid && req[j]) begin
        idx   = IDX_W'(j);
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/de_port_arbiter.sv
// de_port_arbiter: round-robin sharing of the display-engine memory port among
// N_REQ drawing units, one transfer per grant turn, no payload buffering.
//   clk, rst                 clock, asynchronous active-high reset
//   m_req/m_ack              per-requester request (held until ack) / complete strobe
//   m_addr/m_nbyte/m_rnw/m_w_data  packed per-requester payload, requester i at [i*W +: W]
//   m_r_data                 downstream read data fanned out (valid with m_ack[i])
//   m_lock                   hold grant across transfers (only with DE_ARB_LOCK_EN)
//   de_*                     single downstream frame-store port
//   grant_id                 registered current grantee
//   busy                     high while in the GRANT state
// Configuration macro: DE_ARB_LOCK_EN enables the m_lock grant hold; when undefined
// m_lock is accepted but ignored and arbitration is pure round-robin.
module de_port_arbiter
  import de_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = DE_ADDR_W,
  parameter int DATA_W  = DE_DATA_W,
  parameter int NBYTE_W = DE_NBYTE_W,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         m_req,
  output logic [N_REQ-1:0]         m_ack,
  input  logic [N_REQ*ADDR_W-1:0]  m_addr,
  input  logic [N_REQ*NBYTE_W-1:0] m_nbyte,
  input  logic [N_REQ-1:0]         m_rnw,
  input  logic [N_REQ*DATA_W-1:0]  m_w_data,
  output logic [DATA_W-1:0]        m_r_data,
  input  logic [N_REQ-1:0]         m_lock,
  output logic                     de_req,
  input  logic                     de_ack,
  output logic [ADDR_W-1:0]        de_addr,
  output logic [NBYTE_W-1:0]       de_nbyte,
  output logic                     de_rnw,
  output logic [DATA_W-1:0]        de_w_data,
  input  logic [DATA_W-1:0]        de_r_data,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last, last_nxt, grant_nxt;
  logic [IDX_W-1:0] pick_base, pick_idx;
  logic             pick_valid;
  logic             cur_req;
  logic             hold_lock;

  // In IDLE the search continues from the last served requester; in GRANT it
  // rotates away from the current grantee.
  assign pick_base = (state == ARB_GRANT) ? grant_id : last;
  assign cur_req   = m_req[grant_id];

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (m_req),
    .last  (pick_base),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef DE_ARB_LOCK_EN
  assign hold_lock = m_lock[grant_id] & cur_req;
`else
  logic unused_lock;
  assign unused_lock = &{1'b0, m_lock};
  assign hold_lock   = 1'b0;
`endif

  // State, grantee and last-served registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant_id <= {IDX_W{1'b0}};
      last     <= {IDX_W{1'b0}};
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last     <= last_nxt;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nxt = ARB_GRANT;
          grant_nxt = pick_idx;
        end else begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (!cur_req) begin
          // Grantee withdrew; its request is gone so any ack this cycle is ignored.
          state_nxt = ARB_IDLE;
        end else if (de_ack) begin
          last_nxt = grant_id;
          if (hold_lock) begin
            grant_nxt = grant_id;
          end else if (pick_valid) begin
            grant_nxt = pick_idx;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else begin
          state_nxt = ARB_GRANT;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Downstream request, ack pass-through and payload mux driven from the grantee.
  always_comb begin
    de_req    = 1'b0;
    m_ack     = {N_REQ{1'b0}};
    de_addr   = {ADDR_W{1'b0}};
    de_nbyte  = {NBYTE_W{1'b0}};
    de_rnw    = 1'b0;
    de_w_data = {DATA_W{1'b0}};
    if (state == ARB_GRANT) begin
      de_req    = cur_req;
      de_addr   = m_addr[grant_id*ADDR_W +: ADDR_W];
      de_nbyte  = m_nbyte[grant_id*NBYTE_W +: NBYTE_W];
      de_rnw    = m_rnw[grant_id];
      de_w_data = m_w_data[grant_id*DATA_W +: DATA_W];
      if (cur_req && de_ack) begin
        m_ack = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
      end else begin
        m_ack = {N_REQ{1'b0}};
      end
    end else begin
      de_req = 1'b0;
    end
  end

  assign m_r_data = de_r_data;
  assign busy     = (state == ARB_GRANT);

endmodule

// File: tb/tb_de_port_arbiter.sv
// Testbench for de_port_arbiter: scenario tasks with a queue scoreboard of
// expected m_ack vectors, consumed whenever the DUT acknowledges a transfer.
module tb_de_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_ack;
  logic [N*AW-1:0] m_addr;
  logic [N*BW-1:0] m_nbyte;
  logic [N-1:0]    m_rnw;
  logic [N*DW-1:0] m_w_data;
  logic [DW-1:0]   m_r_data;
  logic [N-1:0]    m_lock;
  logic            de_req;
  logic            de_ack;
  logic [AW-1:0]   de_addr;
  logic [BW-1:0]   de_nbyte;
  logic            de_rnw;
  logic [DW-1:0]   de_w_data;
  logic [DW-1:0]   de_r_data;
  logic [1:0]      grant_id;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] addr_tab [N];
  logic [N-1:0]  exp_q [$];

  de_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NBYTE_W(BW)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_ack(m_ack), .m_addr(m_addr),
    .m_nbyte(m_nbyte), .m_rnw(m_rnw), .m_w_data(m_w_data), .m_r_data(m_r_data),
    .m_lock(m_lock), .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr),
    .de_nbyte(de_nbyte), .de_rnw(de_rnw), .de_w_data(de_w_data),
    .de_r_data(de_r_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Start of a cycle: just after the rising edge, inputs may be changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Consume one scoreboard entry if the DUT acknowledges this cycle.
  task automatic monitor(input string name);
    logic [N-1:0] exp;
    if (m_ack !== {N{1'b0}}) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s unexpected ack: got %b expected none", name, m_ack);
      end else begin
        exp = exp_q.pop_front();
        if (m_ack !== exp) begin
          bad++;
          $display("FAIL %s ack: got %b expected %b", name, m_ack, exp);
        end
        total++;
        if (de_addr !== addr_tab[grant_id]) begin
          bad++;
          $display("FAIL %s addr: got %h expected %h", name, de_addr, addr_tab[grant_id]);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s drained: got %0d pending expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({de_req, busy, grant_id, m_ack, de_addr} !== {1'b0, 1'b0, 2'd0, 4'b0000, 18'h0}) begin
      bad++;
      $display("FAIL reset_state: got req=%b busy=%b gid=%0d ack=%b addr=%h expected all 0",
               de_req, busy, grant_id, m_ack, de_addr);
    end
    cyc(); rst = 1'b0; m_req = 4'b1000;
    cyc();
    @(negedge clk);
    total++;
    if (de_req !== 1'b1 || grant_id !== 2'd3) begin
      bad++;
      $display("FAIL reset_pregrant: got req=%b gid=%0d expected 1 3", de_req, grant_id);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (de_req !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_grant: got req=%b busy=%b gid=%0d expected 0 0 0",
               de_req, busy, grant_id);
    end
    cyc(); rst = 1'b0; m_req = 4'b0000;
    cyc();
  endtask

  // One complete transfer from requester idx; leaves last == idx.
  task automatic test_single(input int idx);
    logic [N-1:0] one;
    one = 4'b0001 << idx;
    cyc(); m_req = one; de_ack = 1'b0; de_r_data = 32'hCAFE_0000 + 32'(idx);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || de_req !== 1'b0) begin
      bad++;
      $display("FAIL single_latency: got busy=%b req=%b expected 0 0", busy, de_req);
    end
    cyc(); de_ack = 1'b1;
    @(negedge clk);
    total++;
    if (grant_id !== 2'(idx) || de_req !== 1'b1 || de_addr !== addr_tab[idx] ||
        de_nbyte !== 4'(idx) || de_rnw !== m_rnw[idx] ||
        de_w_data !== (32'hD000_0000 | 32'(idx))) begin
      bad++;
      $display("FAIL single_payload: got gid=%0d req=%b addr=%h nb=%h rnw=%b wd=%h expected gid=%0d",
               grant_id, de_req, de_addr, de_nbyte, de_rnw, de_w_data, idx);
    end
    total++;
    if (m_ack !== one || m_r_data !== (32'hCAFE_0000 + 32'(idx))) begin
      bad++;
      $display("FAIL single_ack: got ack=%b rd=%h expected %b", m_ack, m_r_data, one);
    end
    cyc(); m_req = 4'b0000; de_ack = 1'b0;
    @(negedge clk);
    total++;
    if (de_req !== 1'b0 || m_ack !== 4'b0000) begin
      bad++;
      $display("FAIL single_release: got req=%b ack=%b expected 0 0000", de_req, m_ack);
    end
    cyc();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: got busy=%b expected 0", busy);
    end
  endtask

  // All four requesting, ack every cycle (including while IDLE, which must be ignored).
  task automatic test_fairness();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    cyc(); m_req = 4'b1111; de_ack = 1'b1;
    @(negedge clk);
    total++;
    if (m_ack !== 4'b0000) begin
      bad++;
      $display("FAIL fair_idle_ack: got %b expected 0000", m_ack);
    end
    for (int c = 0; c < 5; c++) begin
      cyc();
      @(negedge clk);
      monitor("fairness");
    end
    cyc(); m_req = 4'b0000; de_ack = 1'b0;
    cyc();
    check_drained("fairness");
  endtask

  task automatic test_streaming();
    int gaps;
    gaps = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(4'b0001);
    cyc(); m_req = 4'b0001; de_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      @(negedge clk);
      if (busy !== 1'b1 || de_req !== 1'b1) gaps++;
      monitor("streaming");
    end
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL stream_gap: got %0d idle cycles expected 0", gaps);
    end
    cyc(); m_req = 4'b0000; de_ack = 1'b0;
    cyc();
    check_drained("streaming");
  endtask

  task automatic test_withdrawal();
    cyc(); m_req = 4'b0010; de_ack = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if (grant_id !== 2'd1 || de_req !== 1'b1) begin
      bad++;
      $display("FAIL wd_grant: got gid=%0d req=%b expected 1 1", grant_id, de_req);
    end
    cyc(); m_req = 4'b0000; de_ack = 1'b1;
    @(negedge clk);
    total++;
    if (de_req !== 1'b0 || m_ack !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wd_drop: got req=%b ack=%b busy=%b expected 0 0000 1", de_req, m_ack, busy);
    end
    cyc();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_ack !== 4'b0000) begin
      bad++;
      $display("FAIL wd_idle: got busy=%b ack=%b expected 0 0000", busy, m_ack);
    end
    cyc(); de_ack = 1'b0;
  endtask

  // Requires last == 1 on entry so the first grant goes to requester 0.
  task automatic test_lock();
`ifdef DE_ARB_LOCK_EN
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
`else
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
`endif
    cyc(); m_req = 4'b0011; m_lock = 4'b0001; de_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(); de_ack = 1'b1; m_lock = (c < 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      monitor("lock");
    end
    cyc(); m_req = 4'b0000; m_lock = 4'b0000; de_ack = 1'b0;
    cyc();
    check_drained("lock");
  endtask

  initial begin
    addr_tab[0] = 18'h00011; addr_tab[1] = 18'h00022;
    addr_tab[2] = 18'h000A0; addr_tab[3] = 18'h00033;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]   = addr_tab[i];
      m_nbyte[i*BW +: BW]  = 4'(i);
      m_w_data[i*DW +: DW] = 32'hD000_0000 | 32'(i);
    end
    m_rnw     = 4'b1010;
    m_req     = 4'b0000;
    m_lock    = 4'b0000;
    de_ack    = 1'b0;
    de_r_data = 32'h0;
    rst       = 1'b1;

    test_reset();
    test_single(2);
    test_single(3);
    test_fairness();
    test_streaming();
    test_withdrawal();
    test_single(1);
    test_lock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
